ser_frame_collector: RTL and testbench

- Downstream stage of the serial sequence-detector/counter block.
- Consumes its serial payload stream (ser_out / ser_out_valid) and assembles each contiguous valid burst into a right-justified parallel word with its bit count.
- Presents the word to a parallel consumer through a one-entry valid/ready holding register.
- Counts frames dropped under backpressure.

---
 rtl/ser_frame_collector.sv | 105 ++++++++++
 tb/tb_ser_frame_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_collector.sv
// Serial frame collector: packs each contiguous valid burst of the upstream
// payload stream into a right-justified word and hands it off via valid/ready.
module ser_frame_collector #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              ser_in,
    input  logic              ser_in_valid,
    input  logic              frame_ready,
    output logic              frame_valid,
    output logic [DATA_W-1:0] frame_data,
    output logic [LEN_W-1:0]  frame_len,
    output logic              frame_ovf,
    output logic [3:0]        drop_cnt,
    output logic              busy
);

    localparam logic S_IDLE    = 1'b0;
    localparam logic S_COLLECT = 1'b1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    logic              state;
    logic [DATA_W-1:0] shreg;
    logic [LEN_W-1:0]  cnt;
    logic              ovf;

    logic frame_end;
    logic load_ok;
    logic commit;
    logic drop;

    // A frame ends on the first enabled edge with no qualifier after a burst.
    assign frame_end = clk_en && (state == S_COLLECT) && !ser_in_valid;
    assign load_ok   = !frame_valid || frame_ready;
    assign commit    = frame_end && load_ok;
    assign drop      = frame_end && !load_ok;
    assign busy      = (state == S_COLLECT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (ser_in_valid) begin
                        state <= S_COLLECT;
                        shreg <= {{(DATA_W-1){1'b0}}, ser_in};
                        cnt   <= LEN_W'(1);
                        ovf   <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (ser_in_valid) begin
                        // Past DATA_W bits the tail is discarded, only flagged.
                        if (cnt < MAX_LEN) begin
                            shreg <= {shreg[DATA_W-2:0], ser_in};
                            cnt   <= cnt + LEN_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        shreg <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Holding register runs every edge; only the commit depends on clk_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_len   <= '0;
            frame_ovf   <= 1'b0;
        end else if (commit) begin
            frame_valid <= 1'b1;
            frame_data  <= shreg;
            frame_len   <= cnt;
            frame_ovf   <= ovf;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 4'd0;
        end else if (drop && (drop_cnt != 4'hF)) begin
            drop_cnt <= drop_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ser_frame_collector.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops
// and compares them whenever the consumer accepts a frame.
module tb_ser_frame_collector;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [LEN_W-1:0]  l;
        logic              o;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              ser_in;
    logic              ser_in_valid;
    logic              frame_ready;
    logic              frame_valid;
    logic [DATA_W-1:0] frame_data;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_ovf;
    logic [3:0]        drop_cnt;
    logic              busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    ser_frame_collector #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .ser_in       (ser_in),
        .ser_in_valid (ser_in_valid),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_len    (frame_len),
        .frame_ovf    (frame_ovf),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic en, input logic v, input logic b);
        clk_en       = en;
        ser_in_valid = v;
        ser_in       = b;
        step();
    endtask

    // Drive n payload bits, first-sent bit taken from index n-1.
    task automatic burst(input logic [31:0] bits, input int n);
        logic [31:0] w;
        w = bits;
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, w[i]);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l, input logic o);
        exp_t e;
        e.d = d; e.l = l; e.o = o;
        sb.push_back(e);
    endtask

    // Monitor: inputs change only just after posedge, so the negedge view
    // matches what the next edge will act on.
    always @(negedge clk) begin
        if (rst === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame: got data=%0h len=%0d ovf=%0b expected none",
                         frame_data, frame_len, frame_ovf);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (frame_data !== e.d || frame_len !== e.l || frame_ovf !== e.o) begin
                    bad++;
                    $display("FAIL frame: got data=%0h len=%0d ovf=%0b expected data=%0h len=%0d ovf=%0b",
                             frame_data, frame_len, frame_ovf, e.d, e.l, e.o);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; clk_en = 1'b0; ser_in = 1'b0; ser_in_valid = 1'b0; frame_ready = 1'b1;
        step();
        chk("reset_valid", {31'd0, frame_valid}, 32'd0);
        chk("reset_drop", {28'd0, drop_cnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        step();

        // Basic frame 1,0,1,1,0
        push(16'h0016, 5'd5, 1'b0);
        burst(32'b10110, 5);
        chk("basic_busy_mid", {31'd0, busy}, 32'd1);
        chk("basic_valid_early", {31'd0, frame_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("basic_valid_rise", {31'd0, frame_valid}, 32'd1);
        chk("basic_busy_fall", {31'd0, busy}, 32'd0);
        step();
        chk("basic_valid_fall", {31'd0, frame_valid}, 32'd0);

        // Clock-enable gating: disabled cycles carry garbage and a fake frame end
        push(16'h0007, 5'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
        chk("gate_busy_hold", {31'd0, busy}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("gate_valid", {31'd0, frame_valid}, 32'd1);
        step();

        // Overflow: 18 bits, first 16 = A5C3
        push(16'hA5C3, 5'd16, 1'b1);
        burst(32'h0002_970F, 18);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ovf_valid", {31'd0, frame_valid}, 32'd1);
        step();

        // Backpressure: A held, B dropped
        frame_ready = 1'b0;
        push(16'h0005, 5'd3, 1'b0);
        burst(32'b101, 3);
        cyc(1'b1, 1'b0, 1'b0);
        burst(32'b11, 2);
        cyc(1'b1, 1'b0, 1'b0);
        chk("bp_hold_valid", {31'd0, frame_valid}, 32'd1);
        chk("bp_hold_data", {16'd0, frame_data}, 32'h0005);
        chk("bp_hold_len", {27'd0, frame_len}, 32'd3);
        chk("bp_drop", {28'd0, drop_cnt}, 32'd1);
        frame_ready = 1'b1;
        step();
        chk("bp_accept_fall", {31'd0, frame_valid}, 32'd0);

        // Simultaneous commit and accept
        frame_ready = 1'b0;
        push(16'h0005, 5'd3, 1'b0);
        burst(32'b101, 3);
        cyc(1'b1, 1'b0, 1'b0);
        push(16'h0003, 5'd2, 1'b0);
        burst(32'b11, 2);
        frame_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("sim_valid_stays", {31'd0, frame_valid}, 32'd1);
        chk("sim_data_b", {16'd0, frame_data}, 32'h0003);
        chk("sim_drop_same", {28'd0, drop_cnt}, 32'd1);
        step();
        chk("sim_valid_fall", {31'd0, frame_valid}, 32'd0);

        // Reset mid-frame, asynchronous
        burst(32'b1111, 4);
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_data", {16'd0, frame_data}, 32'd0);
        chk("rst_len", {27'd0, frame_len}, 32'd0);
        chk("rst_ovf", {31'd0, frame_ovf}, 32'd0);
        chk("rst_drop", {28'd0, drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        ser_in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        push(16'h0002, 5'd2, 1'b0);
        burst(32'b10, 2);
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_valid", {31'd0, frame_valid}, 32'd1);
        chk("post_rst_data", {16'd0, frame_data}, 32'h0002);
        step();

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
